// File: rtl/core_dbg_ctrl.sv
// core_dbg_ctrl: debug register file and core run-control sequencer.
// Handles halt, resume and single-step, and injects ITR0..ITR3 into the core
// pipeline while the core is halted.
// Optional build macro: DBG_ITR_TIMEOUT_EN adds an ITR retire watchdog that
// sets err plus a timeout flag (DBGSC bit5) and returns to HALTED.
//
// Register map (dbg_addr):
//   0 DBGSC    {26'b0, tmo, err, busy, step, halted, halt_req}
//              write: bit0=1 requests halt, bit4=1 clears err/tmo
//   1 DRUNCTRL write: bit0=1 resume, bit1=single-step (reads 0)
//   2-5 ITR0-3 instruction words (write only in HALTED, reads 0)
//              writing ITR3 starts injection
//   6 DTR_HI   DTR[63:32]
//   7 DTR_LO   DTR[31:0]
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUNNING   | core running, no debug request outstanding
// HALTING   | halt requested, waiting for core_halted
// HALTED    | core halted, accepting ITR / DRUNCTRL writes
// ITR_ISSUE | presenting ITR[idx] on itr_valid/itr_insn until itr_ready
// ITR_WAIT  | waiting for itr_done of the injected instruction
// RESUMING  | resume (optionally single-step) requested, waiting for run

module core_dbg_ctrl #(
  parameter int ITR_TIMEOUT_CYCLES = 1024,
  parameter int DTR_WIDTH          = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dbg_wr_en,
  input  logic                 dbg_rd_en,
  input  logic [3:0]           dbg_addr,
  input  logic [31:0]          dbg_wdata,
  output logic [31:0]          dbg_rdata,
  output logic                 dbg_rvalid,
  output logic                 core_halt_req,
  input  logic                 core_halted,
  output logic                 core_resume_req,
  output logic                 core_step,
  output logic                 itr_valid,
  output logic [31:0]          itr_insn,
  input  logic                 itr_ready,
  input  logic                 itr_done,
  input  logic                 itr_err,
  input  logic                 core_dtr_wr,
  input  logic [DTR_WIDTH-1:0] core_dtr_wdata,
  output logic [DTR_WIDTH-1:0] dtr_value
);

  typedef enum logic [2:0] {
    RUNNING   = 3'd0,
    HALTING   = 3'd1,
    HALTED    = 3'd2,
    ITR_ISSUE = 3'd3,
    ITR_WAIT  = 3'd4,
    RESUMING  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [31:0]          itr_q [4];
  logic [1:0]           idx_q;
  logic                 step_q;
  logic                 err_q;
  logic                 tmo_q;
  logic                 tmo_fire;
  logic [DTR_WIDTH-1:0] dtr_q;
  logic [31:0]          rd_mux;
  logic [31:0]          dbgsc_val;
  logic                 busy;
  logic                 halted_st;

  // Register-file write decode
  logic wr_dbgsc, wr_drun, wr_itr3, wr_dtr_hi, wr_dtr_lo;
  assign wr_dbgsc  = dbg_wr_en && (dbg_addr == 4'd0);
  assign wr_drun   = dbg_wr_en && (dbg_addr == 4'd1);
  assign wr_itr3   = dbg_wr_en && (dbg_addr == 4'd5);
  assign wr_dtr_hi = dbg_wr_en && (dbg_addr == 4'd6);
  assign wr_dtr_lo = dbg_wr_en && (dbg_addr == 4'd7);

  logic itr_last;
  assign itr_last = (idx_q == 2'd3);

`ifdef DBG_ITR_TIMEOUT_EN
  localparam int TMO_W = ($clog2(ITR_TIMEOUT_CYCLES) > 0) ? $clog2(ITR_TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog down-counter: reloaded on entry to ITR_WAIT, fires at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (next_state == ITR_WAIT && state != ITR_WAIT) begin
      tmo_cnt <= TMO_W'(ITR_TIMEOUT_CYCLES - 1);
    end else if (state == ITR_WAIT && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_fire = (state == ITR_WAIT) && !itr_done && (tmo_cnt == '0);

  // Sticky timeout flag, cleared with err by DBGSC bit4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else if (tmo_fire) begin
      tmo_q <= 1'b1;
    end else if (wr_dbgsc && dbg_wdata[4]) begin
      tmo_q <= 1'b0;
    end
  end
`else
  localparam int unused_itr_timeout = ITR_TIMEOUT_CYCLES;
  assign tmo_fire = 1'b0;
  assign tmo_q    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUNNING;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      RUNNING: begin
        if (wr_dbgsc && dbg_wdata[0]) next_state = HALTING;
      end
      HALTING: begin
        if (core_halted) next_state = HALTED;
      end
      HALTED: begin
        if (wr_itr3) next_state = ITR_ISSUE;
        else if (wr_drun && dbg_wdata[0]) next_state = RESUMING;
      end
      ITR_ISSUE: begin
        if (itr_ready) next_state = ITR_WAIT;
      end
      ITR_WAIT: begin
        if (itr_done) begin
          if (itr_err || itr_last) next_state = HALTED;
          else next_state = ITR_ISSUE;
        end else if (tmo_fire) begin
          next_state = HALTED;
        end
      end
      RESUMING: begin
        if (!core_halted) next_state = step_q ? HALTING : RUNNING;
      end
      default: next_state = RUNNING;
    endcase
  end

  // Output decode; the core stays under halt request during injection
  always_comb begin
    core_halt_req   = 1'b0;
    core_resume_req = 1'b0;
    core_step       = 1'b0;
    itr_valid       = 1'b0;
    itr_insn        = 32'h0;
    busy            = 1'b0;
    halted_st       = 1'b0;
    case (state)
      HALTING: core_halt_req = 1'b1;
      HALTED: begin
        core_halt_req = 1'b1;
        halted_st     = 1'b1;
      end
      ITR_ISSUE: begin
        core_halt_req = 1'b1;
        halted_st     = 1'b1;
        busy          = 1'b1;
        itr_valid     = 1'b1;
        itr_insn      = itr_q[idx_q];
      end
      ITR_WAIT: begin
        core_halt_req = 1'b1;
        halted_st     = 1'b1;
        busy          = 1'b1;
      end
      RESUMING: begin
        core_resume_req = 1'b1;
        core_step       = step_q;
      end
      default: ;
    endcase
  end

  // ITR storage: writable only while halted and idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) itr_q[i] <= 32'h0;
    end else if (dbg_wr_en && state == HALTED) begin
      for (int i = 0; i < 4; i++) begin
        if (dbg_addr == 4'(i + 2)) itr_q[i] <= dbg_wdata;
      end
    end
  end

  // Injection index: restart on ITR3 write, advance on clean retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
    end else if (state == HALTED && wr_itr3) begin
      idx_q <= 2'd0;
    end else if (state == ITR_WAIT && itr_done && !itr_err && !itr_last) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Step flag: latched on resume, dropped once the re-halt completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else if (state == HALTED && wr_drun && dbg_wdata[0]) begin
      step_q <= dbg_wdata[1];
    end else if (state == HALTING && core_halted) begin
      step_q <= 1'b0;
    end
  end

  // Sticky error: retire exception, illegal ITR3 write or watchdog; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state == ITR_WAIT && itr_done && itr_err) ||
                 (wr_itr3 && state != HALTED) || tmo_fire) begin
      err_q <= 1'b1;
    end else if (wr_dbgsc && dbg_wdata[4]) begin
      err_q <= 1'b0;
    end
  end

  // DTR: a core write replaces the whole register and beats debug writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtr_q <= '0;
    end else if (core_dtr_wr) begin
      dtr_q <= core_dtr_wdata;
    end else if (wr_dtr_hi) begin
      dtr_q[DTR_WIDTH-1:DTR_WIDTH-32] <= dbg_wdata;
    end else if (wr_dtr_lo) begin
      dtr_q[31:0] <= dbg_wdata;
    end
  end

  assign dtr_value = dtr_q;
  assign dbgsc_val = {26'b0, tmo_q, err_q, busy, step_q, halted_st, core_halt_req};

  // Read mux sees current (pre-write) register contents
  always_comb begin
    rd_mux = 32'h0;
    case (dbg_addr)
      4'd0:    rd_mux = dbgsc_val;
      4'd6:    rd_mux = dtr_q[DTR_WIDTH-1:DTR_WIDTH-32];
      4'd7:    rd_mux = dtr_q[31:0];
      default: rd_mux = 32'h0;
    endcase
  end

  // Registered read data and one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata  <= 32'h0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= dbg_rd_en;
      if (dbg_rd_en) dbg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_core_dbg_ctrl.sv
// Directed self-checking bench for core_dbg_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_core_dbg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_wr_en, dbg_rd_en;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_rvalid;
  logic        core_halt_req, core_halted, core_resume_req, core_step;
  logic        itr_valid, itr_ready, itr_done, itr_err;
  logic [31:0] itr_insn;
  logic        core_dtr_wr;
  logic [63:0] core_dtr_wdata, dtr_value;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  core_dbg_ctrl #(.ITR_TIMEOUT_CYCLES(16), .DTR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_wr_en(dbg_wr_en), .dbg_rd_en(dbg_rd_en), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .core_halt_req(core_halt_req), .core_halted(core_halted),
    .core_resume_req(core_resume_req), .core_step(core_step),
    .itr_valid(itr_valid), .itr_insn(itr_insn), .itr_ready(itr_ready),
    .itr_done(itr_done), .itr_err(itr_err),
    .core_dtr_wr(core_dtr_wr), .core_dtr_wdata(core_dtr_wdata),
    .dtr_value(dtr_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; the write is taken on the rising edge between
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    dbg_wr_en = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    dbg_rd_en = 1'b1; dbg_addr = a;
    @(negedge clk);
    dbg_rd_en = 1'b0;
    chk("rvalid", dbg_rvalid, 1);
    d = dbg_rdata;
  endtask

  // One injected instruction with ready held high and done two cycles after issue
  task automatic do_itr(input logic [31:0] exp_insn, input logic e);
    int n = 0;
    while (!itr_valid && n < 10) begin @(negedge clk); n++; end
    chk("itr_valid_up", itr_valid, 1);
    chk("itr_insn", itr_insn, exp_insn);
    @(negedge clk);
    chk("itr_valid_wait", itr_valid, 0);
    bus_rd(4'd0, rd);
    chk("dbgsc_busy", rd, 32'h0B);
    itr_done = 1'b1; itr_err = e;
    @(negedge clk);
    itr_done = 1'b0; itr_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dbg_wr_en = 0; dbg_rd_en = 0; dbg_addr = 0; dbg_wdata = 0;
    core_halted = 0; itr_ready = 0; itr_done = 0; itr_err = 0;
    core_dtr_wr = 0; core_dtr_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_halt_req", core_halt_req, 0);
    chk("rst_resume", core_resume_req, 0);
    chk("rst_step", core_step, 0);
    chk("rst_itr_valid", itr_valid, 0);
    chk("rst_itr_insn", itr_insn, 0);
    chk("rst_dtr", dtr_value, 0);
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_rdata", dbg_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rd(4'd0, rd);
    chk("dbgsc_idle", rd, 32'h0);
    @(negedge clk);
    chk("rvalid_pulse", dbg_rvalid, 0);

    // Illegal accesses while running
    bus_wr(4'd5, 32'hBAD);
    chk("itr3_running_no_issue", itr_valid, 0);
    bus_wr(4'd1, 32'h1);
    chk("drun_running_ignored", core_resume_req, 0);
    bus_rd(4'd0, rd);
    chk("dbgsc_err_illegal", rd, 32'h10);
    bus_wr(4'd0, 32'h10);
    bus_rd(4'd0, rd);
    chk("dbgsc_err_cleared", rd, 32'h0);

    // Halt: core_halted rises 3 cycles after the request
    bus_wr(4'd0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("halting_req", core_halt_req, 1);
      if (i < 2) @(negedge clk);
    end
    core_halted = 1'b1;
    @(negedge clk);
    chk("halted_req", core_halt_req, 1);
    bus_rd(4'd0, rd);
    chk("dbgsc_halted", rd, 32'h03);
    bus_rd(4'd1, rd);
    chk("drunctrl_reads0", rd, 32'h0);

    // Four-instruction injection; first issue holds while itr_ready is low
    bus_wr(4'd2, 32'h13);
    bus_wr(4'd3, 32'h93);
    bus_wr(4'd4, 32'h113);
    bus_rd(4'd2, rd);
    chk("itr_reads0", rd, 32'h0);
    bus_wr(4'd5, 32'h193);
    chk("issue_hold_valid", itr_valid, 1);
    chk("issue_hold_insn", itr_insn, 32'h13);
    @(negedge clk);
    chk("issue_hold_valid2", itr_valid, 1);
    chk("issue_hold_insn2", itr_insn, 32'h13);
    itr_ready = 1'b1;
    do_itr(32'h13, 0);
    do_itr(32'h93, 0);
    do_itr(32'h113, 0);
    do_itr(32'h193, 0);
    chk("itr_done_valid", itr_valid, 0);
    bus_rd(4'd0, rd);
    chk("dbgsc_after_itr", rd, 32'h03);

    // Exception on ITR1 aborts ITR2/ITR3
    bus_wr(4'd5, 32'h193);
    do_itr(32'h13, 0);
    do_itr(32'h93, 1);
    chk("abort_no_issue", itr_valid, 0);
    @(negedge clk);
    chk("abort_no_issue2", itr_valid, 0);
    bus_rd(4'd0, rd);
    chk("dbgsc_err", rd, 32'h13);
    bus_wr(4'd0, 32'h10);
    bus_rd(4'd0, rd);
    chk("dbgsc_err_w1c", rd, 32'h03);

    // Single step: resume, core leaves halt, automatic re-halt
    bus_wr(4'd1, 32'h3);
    chk("step_resume_req", core_resume_req, 1);
    chk("step_core_step", core_step, 1);
    chk("step_halt_req_low", core_halt_req, 0);
    @(negedge clk);
    chk("step_resume_held", core_resume_req, 1);
    core_halted = 1'b0;
    @(negedge clk);
    chk("rehalt_req", core_halt_req, 1);
    chk("rehalt_resume_low", core_resume_req, 0);
    chk("rehalt_step_low", core_step, 0);
    core_halted = 1'b1;
    @(negedge clk);
    bus_rd(4'd0, rd);
    chk("dbgsc_rehalted", rd, 32'h03);

    // Plain resume back to running
    bus_wr(4'd1, 32'h1);
    chk("resume_req", core_resume_req, 1);
    chk("resume_no_step", core_step, 0);
    core_halted = 1'b0;
    @(negedge clk);
    chk("running_halt_req", core_halt_req, 0);
    chk("running_resume", core_resume_req, 0);
    bus_rd(4'd0, rd);
    chk("dbgsc_running", rd, 32'h0);

    // DTR: core write beats debug write in the same cycle
    core_dtr_wr = 1'b1; core_dtr_wdata = 64'h1234;
    bus_wr(4'd7, 32'hDEADBEEF);
    core_dtr_wr = 1'b0;
    chk("dtr_core_wins", dtr_value, 64'h1234);
    bus_rd(4'd7, rd);
    chk("dtr_lo_read", rd, 32'h00001234);
    bus_wr(4'd6, 32'hCAFEF00D);
    chk("dtr_hi_write", dtr_value, 64'hCAFEF00D_00001234);
    dbg_rd_en = 1'b1; dbg_wr_en = 1'b1; dbg_addr = 4'd7; dbg_wdata = 32'h5555;
    @(negedge clk);
    dbg_rd_en = 1'b0; dbg_wr_en = 1'b0;
    chk("rd_wr_prewrite", dbg_rdata, 32'h00001234);
    chk("rd_wr_dtr", dtr_value, 64'hCAFEF00D_00005555);

    // Halt again for the remaining scenarios
    bus_wr(4'd0, 32'h1);
    core_halted = 1'b1;
    @(negedge clk);
    bus_rd(4'd0, rd);
    chk("dbgsc_halted2", rd, 32'h03);

`ifdef DBG_ITR_TIMEOUT_EN
    // Withheld itr_done: watchdog returns to HALTED after 16 cycles in ITR_WAIT
    bus_wr(4'd5, 32'h193);
    chk("tmo_issue", itr_valid, 1);
    @(negedge clk);
    chk("tmo_wait", itr_valid, 0);
    repeat (15) @(negedge clk);
    bus_rd(4'd0, rd);
    chk("tmo_still_waiting", rd, 32'h0B);
    bus_rd(4'd0, rd);
    chk("tmo_fired", rd, 32'h33);
    bus_wr(4'd0, 32'h10);
    bus_rd(4'd0, rd);
    chk("tmo_w1c", rd, 32'h03);
`endif

    // Reset in the middle of an injection
    itr_ready = 1'b0;
    bus_wr(4'd5, 32'h193);
    chk("pre_rst_valid", itr_valid, 1);
    rst_n = 1'b0; core_halted = 1'b0;
    #1;
    chk("midrst_valid", itr_valid, 0);
    chk("midrst_insn", itr_insn, 0);
    chk("midrst_halt_req", core_halt_req, 0);
    chk("midrst_dtr", dtr_value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", itr_valid, 0);
    bus_rd(4'd0, rd);
    chk("postrst_dbgsc", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_dbg_ctrl.md
Name: core_dbg_ctrl

Overview:
Core debug-interface controller. Owns the debug register file (DBGSC, DRUNCTRL, ITR0-3, DTR_HI/DTR_LO at offsets 0-7) and sequences core run control: halt, resume and single-step.
While the core is halted, it feeds ITR0..ITR3 one instruction at a time into the core pipeline over a valid/ready handshake and waits for each to retire.
It sits between the external debug bus and the core front end/retire logic.

Parameters:
ITR_TIMEOUT_CYCLES, 1024, ITR retire watchdog limit (used only with DBG_ITR_TIMEOUT_EN)
DTR_WIDTH, 64, data transfer register width (equals core REG_WIDTH)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dbg_wr_en  in  1  debug register write strobe
dbg_rd_en  in  1  debug register read strobe
dbg_addr  in  4  register offset (0 DBGSC, 1 DRUNCTRL, 2-5 ITR0-3, 6 DTR_HI, 7 DTR_LO)
dbg_wdata  in  32  write data
dbg_rdata  out  32  read data, registered
dbg_rvalid  out  1  read data valid pulse
core_halt_req  out  1  request core to halt
core_halted  in  1  core is in halted state
core_resume_req  out  1  request core to leave halt
core_step  out  1  qualifies resume as single-step
itr_valid  out  1  ITR instruction valid to pipeline
itr_insn  out  32  ITR instruction word
itr_ready  in  1  pipeline accepts itr_insn
itr_done  in  1  injected instruction retired (pulse)
itr_err  in  1  retired with exception (valid with itr_done)
core_dtr_wr  in  1  core writes DTR
core_dtr_wdata  in  64  core DTR write data
dtr_value  out  64  current DTR contents to core

Behaviour:
- Reset: state=RUNNING; all outputs 0; ITR0-3, DTR, sticky err, step flag cleared.
- States:
  - RUNNING, HALTING, HALTED, ITR_ISSUE, ITR_WAIT, RESUMING.
- RUNNING:
  - DBGSC write with bit0=1 -> HALTING.
- HALTING:
  - core_halt_req=1.
  - core_halted=1 -> HALTED.
  - If step flag is set, clear it on entry to HALTED.
- HALTED:
  - core_halt_req stays 1.
  - ITR3 write -> ITR_ISSUE with idx=0.
  - DRUNCTRL write bit0=1 -> RESUMING, with step flag = bit1.
  - If ITR3 and DRUNCTRL are written in the same cycle, ITR3 wins.
- ITR_ISSUE:
  - itr_valid=1, itr_insn=ITR[idx], held stable until itr_ready.
  - On the handshake -> ITR_WAIT.
- ITR_WAIT:
  - itr_valid=0.
  - On itr_done with itr_err=1: set sticky err and abort remaining ITRs -> HALTED.
  - On itr_done, else if idx==3 -> HALTED.
  - On itr_done, else idx+1 -> ITR_ISSUE.
  - Total ITR latency is at least 2 cycles per instruction.
- RESUMING:
  - core_halt_req=0, core_resume_req=1, core_step=step flag.
  - Outputs held until core_halted=0.
  - Then: step flag=1 -> HALTING (automatic re-halt); otherwise -> RUNNING.
- Illegal accesses:
  - ITR0-3 writes are ignored unless the state is HALTED.
  - An ITR3 write outside HALTED also sets sticky err.
  - A DRUNCTRL write outside HALTED is ignored.
  - DBGSC bit0=1 written while not RUNNING is a no-op.
- DBGSC read: {27'b0, err, busy, step, halted, halt_req}.
  - busy=1 in ITR_ISSUE/ITR_WAIT.
  - Writing DBGSC bit4=1 clears err (W1C).
- DTR:
  - DTR_HI and DTR_LO writes update bits [63:32] and [31:0] respectively.
  - If core_dtr_wr and a debug DTR write occur in the same cycle, the core write wins.
  - dtr_value always reflects the register.
- Reads:
  - dbg_rdata and dbg_rvalid are valid the cycle after dbg_rd_en.
  - Reading ITR or DRUNCTRL returns 0.
  - A read and a write in the same cycle return the pre-write value.
- rst_n asserted mid-ITR:
  - Returns immediately to RUNNING with all outputs 0.
  - Any in-flight injection is dropped.

Optional Feature:
DBG_ITR_TIMEOUT_EN:
- Defined: a counter runs in ITR_WAIT, cleared on each entry to that state. When it reaches ITR_TIMEOUT_CYCLES without itr_done, the block sets sticky err and a timeout bit (DBGSC bit5), then goes to HALTED. The timeout bit clears with W1C together with err.
- Undefined: ITR_WAIT waits indefinitely, and DBGSC bit5 reads 0.

Test Plan:
- Write DBGSC=0x1; core_halted rises 3 cycles later -> core_halt_req=1 throughout, state HALTED, DBGSC read = 0x03.
- Halted; ITR0..3 = 0x13,0x93,0x113,0x193; write ITR3; itr_ready=1, itr_done 2 cycles after each issue -> four itr_insn handshakes in order, then busy=0.
- During ITR, itr_done on ITR1 with itr_err=1 -> ITR2/ITR3 not issued, state HALTED, DBGSC bit4=1; write DBGSC=0x10 -> bit4=0.
- Halted; write DRUNCTRL=0x3 -> core_resume_req=1, core_step=1 until core_halted falls, then core_halt_req=1 again and HALTED after core_halted re-asserts.
- Write DTR_LO=0xDEADBEEF and core_dtr_wr=1 with 0x1234 in the same cycle -> dtr_value=0x1234; next read of DTR_LO returns 0x00001234.
- With DBG_ITR_TIMEOUT_EN and ITR_TIMEOUT_CYCLES=16, itr_done withheld -> HALTED 16 cycles into ITR_WAIT, DBGSC bits5 and 4 set.
